// File: rtl/sub100_seq.sv
// Multi-cycle wide subtractor: diff = a - b - bin, CHUNK bits per clock with a
// chained borrow, bracketed by a start/busy/done handshake.
module sub100_seq #(
   parameter int WIDTH = 100,
   parameter int CHUNK = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int NCH   = WIDTH / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("sub100_seq: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_work;
   logic [WIDTH-1:0]   r_diff;
   logic [IDX_W-1:0]   r_idx;
   logic               r_brw;
   logic               r_bout;
   logic               r_done;
   logic               w_busy;
   logic               w_accept;
   logic               w_last;
   logic [CHUNK:0]     w_sub;
   logic [WIDTH+CHUNK-1:0] w_cat;
   logic [WIDTH-1:0]   w_work_next;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);

   // Operands shift right each cycle, so the active chunk always sits in the low bits;
   // the top bit of the (CHUNK+1)-bit difference is the borrow out of this chunk.
   assign w_sub = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]} - {{CHUNK{1'b0}}, r_brw};
   assign w_cat = {w_sub[CHUNK-1:0], r_work};
   assign w_work_next = w_cat[WIDTH+CHUNK-1:CHUNK];

   // NOTE: sequential state uses non-blocking assignments only, and the reset branch
   // is asynchronous so every flop clears the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      if (r_state == S_RUN) w_busy = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_work <= '0;
         r_diff <= '0;
         r_idx  <= '0;
         r_brw  <= 1'b0;
         r_bout <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_brw <= bin;
            r_idx <= '0;
         end else if (r_state == S_RUN) begin
            r_a    <= r_a >> CHUNK;
            r_b    <= r_b >> CHUNK;
            r_brw  <= w_sub[CHUNK];
            r_work <= w_work_next;
            r_idx  <= r_idx + IDX_W'(1);
            if (w_last) begin
               r_diff <= w_work_next;
               r_bout <= w_sub[CHUNK];
               r_done <= 1'b1;
               r_idx  <= '0;
            end
         end
      end
   end

   assign busy = w_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;

endmodule

// File: tb/tb_sub100_seq.sv
// Scoreboard bench for sub100_seq: stimulus pushes arithmetic expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_sub100_seq;

   localparam int WIDTH = 100;
   localparam int CHUNK = 10;
   localparam int NCH   = WIDTH / CHUNK;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bout;
      int               done_cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   exp_t             q[$];
   int               cyc = 0;
   int               n_checks = 0;
   int               n_errors = 0;
   logic [WIDTH-1:0] last_diff = '0;
   logic             last_bout = 1'b0;

   sub100_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .diff (diff),
      .bout (bout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, got time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned arithmetic on the whole operands.
   function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                  input logic mbin, input int dcyc);
      exp_t e;
      e.diff     = ma - mb - WIDTH'(mbin);
      e.bout     = ({1'b0, ma} < ({1'b0, mb} + (WIDTH+1)'(mbin)));
      e.done_cyc = dcyc;
      return e;
   endfunction

   function automatic logic [WIDTH-1:0] rnd();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[WIDTH-1:0];
   endfunction

   // Called at a negedge while the DUT is idle; returns just after the accepting edge.
   task automatic start_op(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb, input logic sbin);
      start = 1'b1;
      a     = sa;
      b     = sb;
      bin   = sbin;
      @(posedge clk);
      #1;
      q.push_back(model(sa, sb, sbin, cyc + NCH));
      start = 1'b0;
   endtask

   // Walks negedges until done; while running, busy must be high and outputs held.
   task automatic wait_done();
      for (int k = 0; k < NCH + 8; k++) begin
         @(negedge clk);
         if (done) begin
            check("busy_at_done", {{WIDTH{1'b0}}, busy}, '0);
            return;
         end
         check("busy_running", {{WIDTH{1'b0}}, busy}, {{WIDTH{1'b0}}, 1'b1});
         check("diff_held", {1'b0, diff}, {1'b0, last_diff});
         check("bout_held", {{WIDTH{1'b0}}, bout}, {{WIDTH{1'b0}}, last_bout});
      end
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", NCH + 8);
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("diff", {1'b0, diff}, {1'b0, e.diff});
            check("bout", {{WIDTH{1'b0}}, bout}, {{WIDTH{1'b0}}, e.bout});
            check("latency", (WIDTH+1)'(cyc), (WIDTH+1)'(e.done_cyc));
            last_diff = e.diff;
            last_bout = e.bout;
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] ta;
      logic [WIDTH-1:0] tb;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {{WIDTH{1'b0}}, busy}, '0);
      check("rst_done", {{WIDTH{1'b0}}, done}, '0);
      check("rst_diff", {1'b0, diff}, '0);
      check("rst_bout", {{WIDTH{1'b0}}, bout}, '0);
      rst = 1'b0;
      @(negedge clk);

      // Basic, wrap-around, full borrow ripple, equal operands with borrow-in.
      start_op(WIDTH'(5), WIDTH'(3), 1'b0);
      wait_done();
      start_op('0, WIDTH'(1), 1'b0);
      wait_done();
      ta = '0;
      ta[WIDTH-1] = 1'b1;
      start_op(ta, '0, 1'b1);
      wait_done();
      ta = rnd();
      start_op(ta, ta, 1'b1);
      wait_done();

      // A second start while busy must be ignored entirely.
      @(negedge clk);
      start_op(WIDTH'(9), WIDTH'(4), 1'b0);
      repeat (3) @(negedge clk);
      start = 1'b1;
      a     = WIDTH'(1);
      b     = WIDTH'(1);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      repeat (NCH + 2) @(negedge clk);
      check("idle_after_ignored", {{WIDTH{1'b0}}, busy}, '0);

      // Reset mid-operation aborts with no done pulse.
      start_op(rnd(), rnd(), 1'b1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      q.delete();
      last_diff = '0;
      last_bout = 1'b0;
      check("abort_busy", {{WIDTH{1'b0}}, busy}, '0);
      check("abort_done", {{WIDTH{1'b0}}, done}, '0);
      check("abort_diff", {1'b0, diff}, '0);
      check("abort_bout", {{WIDTH{1'b0}}, bout}, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (NCH + 3) @(negedge clk);
      check("abort_idle", {{WIDTH{1'b0}}, busy}, '0);
      start_op(WIDTH'(7), WIDTH'(2), 1'b0);
      wait_done();

      // Back-to-back random ops, each start issued in the prior done cycle.
      for (int i = 0; i < 200; i++) begin
         ta = rnd();
         tb = rnd();
         case ($urandom_range(0, 7))
            0:       tb = ta;
            1:       ta = '0;
            2:       tb = '1;
            3:       ta = '1;
            default: ;
         endcase
         start_op(ta, tb, 1'($urandom_range(0, 1)));
         wait_done();
      end

      repeat (NCH + 2) @(negedge clk);
      check("queue_drained", (WIDTH+1)'(q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
